// File: rtl/reorder_buffer.sv
// ============================================================================
// Module   : reorder_buffer
// Purpose  : Circular in-order retirement buffer. Results arrive out of order
//            on the CDB and retire in order from the head.
// Options  : REORDER_BUFFER_BYPASS_EN forwards same-cycle CDB results to the
//            read and commit ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reorder_buffer #(
  parameter int REORDER_BUFFER_SIZE_LOG = 4,
  parameter int REGISTER_NUMBER_LOG     = 5,
  parameter int DATA_WIDTH              = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               allocValid,
  input  logic [REGISTER_NUMBER_LOG-1:0]     allocDest,
  output logic                               allocReady,
  output logic [REORDER_BUFFER_SIZE_LOG-1:0] allocTag,
  input  logic                               cdbValid,
  input  logic [REORDER_BUFFER_SIZE_LOG-1:0] cdbTag,
  input  logic [DATA_WIDTH-1:0]              cdbValue,
  input  logic [REORDER_BUFFER_SIZE_LOG-1:0] readTagA,
  input  logic [REORDER_BUFFER_SIZE_LOG-1:0] readTagB,
  output logic                               readReadyA,
  output logic                               readReadyB,
  output logic [DATA_WIDTH-1:0]              readDataA,
  output logic [DATA_WIDTH-1:0]              readDataB,
  output logic                               commitValid,
  output logic [REGISTER_NUMBER_LOG-1:0]     commitDest,
  output logic [DATA_WIDTH-1:0]              commitValue,
  output logic [REORDER_BUFFER_SIZE_LOG-1:0] commitTag,
  input  logic                               commitReady,
  input  logic                               flush,
  output logic [REORDER_BUFFER_SIZE_LOG:0]   count
);

  localparam int c_ENTRIES = 1 << REORDER_BUFFER_SIZE_LOG;
  localparam logic [REORDER_BUFFER_SIZE_LOG:0] c_FULL = {1'b1, {REORDER_BUFFER_SIZE_LOG{1'b0}}};

  logic [c_ENTRIES-1:0]               r_busy;
  logic [c_ENTRIES-1:0]               r_done;
  logic [REGISTER_NUMBER_LOG-1:0]     r_dest  [c_ENTRIES];
  logic [DATA_WIDTH-1:0]              r_value [c_ENTRIES];
  logic [REORDER_BUFFER_SIZE_LOG-1:0] r_head;
  logic [REORDER_BUFFER_SIZE_LOG-1:0] r_tail;
  logic [REORDER_BUFFER_SIZE_LOG:0]   r_count;

  logic                               w_alloc;
  logic                               w_commit;
  logic                               w_cdb_hit;
  logic                               w_head_fwd;
  logic                               w_commit_valid;
  logic [REORDER_BUFFER_SIZE_LOG-1:0] w_rd_tag   [2];
  logic [1:0]                         w_rd_ready;
  logic [DATA_WIDTH-1:0]              w_rd_data  [2];

  // Space is judged from the registered count only, so a commit in the same
  // cycle never makes room for an alloc.
  assign allocReady = (r_count != c_FULL);
  assign allocTag   = r_tail;
  assign count      = r_count;

  assign w_alloc   = allocValid && allocReady;
  assign w_cdb_hit = cdbValid && r_busy[cdbTag];
  assign w_commit  = w_commit_valid && commitReady;

`ifdef REORDER_BUFFER_BYPASS_EN
  assign w_head_fwd = cdbValid && (cdbTag == r_head);
`else
  assign w_head_fwd = 1'b0;
`endif

  assign w_commit_valid = r_busy[r_head] && (r_done[r_head] || w_head_fwd);
  assign commitValid    = w_commit_valid;
  assign commitTag      = r_head;
  assign commitDest     = w_commit_valid ? r_dest[r_head] : '0;
  assign commitValue    = !w_commit_valid ? '0 : (w_head_fwd ? cdbValue : r_value[r_head]);

  assign w_rd_tag[0] = readTagA;
  assign w_rd_tag[1] = readTagB;

  generate
    for (genvar p = 0; p < 2; p++) begin : g_read_port
      logic w_fwd;
`ifdef REORDER_BUFFER_BYPASS_EN
      assign w_fwd = cdbValid && (cdbTag == w_rd_tag[p]);
`else
      assign w_fwd = 1'b0;
`endif
      assign w_rd_ready[p] = r_busy[w_rd_tag[p]] && (r_done[w_rd_tag[p]] || w_fwd);
      assign w_rd_data[p]  = !w_rd_ready[p] ? '0 : (w_fwd ? cdbValue : r_value[w_rd_tag[p]]);
    end
  endgenerate

  assign readReadyA = w_rd_ready[0];
  assign readReadyB = w_rd_ready[1];
  assign readDataA  = w_rd_data[0];
  assign readDataB  = w_rd_data[1];

  // Control state. The tail entry is never busy while an alloc is accepted,
  // so a CDB write aimed at it is dropped and alloc's done=0 stands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy  <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_busy  <= '0;
      r_done  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_cdb_hit) begin
        r_done[cdbTag] <= 1'b1;
      end
      if (w_commit) begin
        r_busy[r_head] <= 1'b0;
        r_head         <= r_head + 1'b1;
      end
      if (w_alloc) begin
        r_busy[r_tail] <= 1'b1;
        r_done[r_tail] <= 1'b0;
        r_tail         <= r_tail + 1'b1;
      end
      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: it is only visible behind busy/done.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      if (w_alloc) begin
        r_dest[r_tail] <= allocDest;
      end
      if (w_cdb_hit) begin
        r_value[cdbTag] <= cdbValue;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
// ============================================================================
// Module   : tb_reorder_buffer
// Purpose  : Self-checking bench for reorder_buffer against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reorder_buffer;

  localparam int N = 16;
`ifdef REORDER_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        allocValid = 1'b0;
  logic [4:0]  allocDest = '0;
  logic        allocReady;
  logic [3:0]  allocTag;
  logic        cdbValid = 1'b0;
  logic [3:0]  cdbTag = '0;
  logic [31:0] cdbValue = '0;
  logic [3:0]  readTagA = '0;
  logic [3:0]  readTagB = '0;
  logic        readReadyA, readReadyB;
  logic [31:0] readDataA, readDataB;
  logic        commitValid;
  logic [4:0]  commitDest;
  logic [31:0] commitValue;
  logic [3:0]  commitTag;
  logic        commitReady = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .reset(reset),
    .allocValid(allocValid), .allocDest(allocDest),
    .allocReady(allocReady), .allocTag(allocTag),
    .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbValue(cdbValue),
    .readTagA(readTagA), .readTagB(readTagB),
    .readReadyA(readReadyA), .readReadyB(readReadyB),
    .readDataA(readDataA), .readDataB(readDataB),
    .commitValid(commitValid), .commitDest(commitDest),
    .commitValue(commitValue), .commitTag(commitTag),
    .commitReady(commitReady), .flush(flush), .count(count)
  );

  // Model: occupied entries in program order, oldest first.
  typedef struct {
    int          tag;
    int          dest;
    bit          done;
    logic [31:0] value;
  } ent_t;

  ent_t q[$];
  int   m_head = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int find(input int t);
    for (int i = 0; i < q.size(); i++)
      if (q[i].tag == t) return i;
    return -1;
  endfunction

  function automatic bit cdb_fwd(input int t);
    return BYP && cdbValid && (int'(cdbTag) == t);
  endfunction

  function automatic bit exp_cvalid();
    if (q.size() == 0) return 1'b0;
    return q[0].done || cdb_fwd(q[0].tag);
  endfunction

  function automatic void exp_read(input int t, output bit rdy, output logic [31:0] d);
    int idx;
    idx = find(t);
    rdy = 1'b0;
    d   = '0;
    if (idx >= 0) begin
      rdy = q[idx].done || cdb_fwd(t);
      if (rdy) d = cdb_fwd(t) ? cdbValue : q[idx].value;
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    int sz, tail, idx;
    bit acc, cm;
    if (reset || flush) begin
      q.delete();
      m_head = 0;
    end else begin
      sz   = q.size();
      tail = (m_head + sz) % N;
      acc  = allocValid && (sz != N);
      cm   = exp_cvalid() && commitReady;
      if (cdbValid) begin
        idx = find(int'(cdbTag));
        if (idx >= 0) begin
          q[idx].done  = 1'b1;
          q[idx].value = cdbValue;
        end
      end
      if (cm) begin
        void'(q.pop_front());
        m_head = (m_head + 1) % N;
      end
      if (acc) q.push_back('{tag: tail, dest: int'(allocDest), done: 1'b0, value: 32'h0});
    end
  end

  always @(negedge clk) begin
    int sz;
    bit cv, ra, rb;
    logic [31:0] da, db, cval;
    sz = q.size();
    cv = exp_cvalid();
    cval = '0;
    if (cv) cval = cdb_fwd(q[0].tag) ? cdbValue : q[0].value;
    exp_read(int'(readTagA), ra, da);
    exp_read(int'(readTagB), rb, db);
    chk("count", 64'(count), 64'(sz));
    chk("allocReady", 64'(allocReady), 64'(sz != N));
    chk("allocTag", 64'(allocTag), 64'((m_head + sz) % N));
    chk("commitValid", 64'(commitValid), 64'(cv));
    chk("commitTag", 64'(commitTag), 64'(m_head));
    chk("commitDest", 64'(commitDest), cv ? 64'(q[0].dest) : 64'd0);
    chk("commitValue", 64'(commitValue), 64'(cval));
    chk("readReadyA", 64'(readReadyA), 64'(ra));
    chk("readDataA", 64'(readDataA), 64'(da));
    chk("readReadyB", 64'(readReadyB), 64'(rb));
    chk("readDataB", 64'(readDataB), 64'(db));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic fill(input int n);
    allocValid = 1'b1;
    for (int i = 0; i < n; i++) begin
      allocDest = 5'(i + 7);
      step();
    end
    allocValid = 1'b0;
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    chk("rst_allocReady", 64'(allocReady), 64'd1);
    chk("rst_allocTag", 64'(allocTag), 64'd0);
    chk("rst_commitValid", 64'(commitValid), 64'd0);
    chk("rst_commitDest", 64'(commitDest), 64'd0);
    chk("rst_commitValue", 64'(commitValue), 64'd0);
    chk("rst_commitTag", 64'(commitTag), 64'd0);
    chk("rst_readReadyA", 64'(readReadyA), 64'd0);
    chk("rst_readReadyB", 64'(readReadyB), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    step();
    reset = 1'b0;

    // Fill to full; 17th alloc rejected
    allocValid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      allocDest = 5'((i + 1) % 32);
      chk("fill_tag", 64'(allocTag), 64'(i));
      step();
    end
    chk("full_count", 64'(count), 64'd16);
    chk("full_allocReady", 64'(allocReady), 64'd0);
    allocDest = 5'd17;
    step();
    allocValid = 1'b0;
    chk("over_tag", 64'(allocTag), 64'd0);
    chk("over_count", 64'(count), 64'd16);
    do_flush();
    chk("flush_count", 64'(count), 64'd0);

    // Out-of-order completion, in-order commit
    fill(2);
    cdbValid = 1'b1; cdbTag = 4'd1; cdbValue = 32'hBEEF;
    step();
    chk("ooo_wait", 64'(commitValid), 64'd0);
    cdbTag = 4'd0; cdbValue = 32'h1234;
    step();
    cdbValid = 1'b0;
    chk("ooo_cv0", 64'(commitValid), 64'd1);
    chk("ooo_val0", 64'(commitValue), 64'h1234);
    chk("ooo_dest0", 64'(commitDest), 64'd7);
    commitReady = 1'b1;
    step();
    chk("ooo_val1", 64'(commitValue), 64'hBEEF);
    chk("ooo_tag1", 64'(commitTag), 64'd1);
    step();
    commitReady = 1'b0;
    chk("ooo_empty", 64'(count), 64'd0);

    // Full buffer: commit and alloc same cycle
    do_flush();
    fill(16);
    cdbValid = 1'b1; cdbTag = 4'd0; cdbValue = 32'h55;
    step();
    cdbValid = 1'b0;
    allocValid = 1'b1; commitReady = 1'b1;
    step();
    allocValid = 1'b0; commitReady = 1'b0;
    chk("fc_count", 64'(count), 64'd15);
    chk("fc_ready", 64'(allocReady), 64'd1);
    chk("fc_tail", 64'(allocTag), 64'd0);

    // Tail wrap over 20 alloc/commit pairs
    do_flush();
    for (int i = 0; i < 20; i++) begin
      allocValid = 1'b1; allocDest = 5'(i);
      chk("wrap_tag", 64'(allocTag), 64'(i % 16));
      step();
      allocValid = 1'b0;
      cdbValid = 1'b1; cdbTag = 4'(i % 16); cdbValue = 32'(i);
      step();
      cdbValid = 1'b0; commitReady = 1'b1;
      chk("wrap_cv", 64'(commitValid), 64'd1);
      step();
      commitReady = 1'b0;
      chk("wrap_le16", 64'(count <= 5'd16), 64'd1);
    end

    // Bypass visibility
    do_flush();
    fill(4);
    cdbValid = 1'b1; cdbTag = 4'd3; cdbValue = 32'hA5; readTagA = 4'd3;
    #1;
    chk("byp_rdy_same", 64'(readReadyA), 64'(BYP));
    chk("byp_dat_same", 64'(readDataA), BYP ? 64'hA5 : 64'h0);
    step();
    cdbValid = 1'b0;
    chk("byp_rdy_next", 64'(readReadyA), 64'd1);
    chk("byp_dat_next", 64'(readDataA), 64'hA5);

    // Flush with simultaneous alloc/CDB
    do_flush();
    fill(5);
    flush = 1'b1; allocValid = 1'b1; cdbValid = 1'b1; cdbTag = 4'd2;
    step();
    flush = 1'b0; allocValid = 1'b0; cdbValid = 1'b0;
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_cv", 64'(commitValid), 64'd0);
    chk("fl_tag", 64'(allocTag), 64'd0);

    // Asynchronous reset mid-stream
    fill(5);
    cdbValid = 1'b1; cdbTag = 4'd0; cdbValue = 32'h77;
    step();
    allocValid = 1'b1; commitReady = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("ar_count", 64'(count), 64'd0);
    chk("ar_cv", 64'(commitValid), 64'd0);
    chk("ar_tag", 64'(allocTag), 64'd0);
    chk("ar_ready", 64'(allocReady), 64'd1);
    step();
    reset = 1'b0; allocValid = 1'b0; commitReady = 1'b0; cdbValid = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      allocValid  = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      allocDest   = 5'($urandom);
      cdbValid    = $urandom_range(0, 1) == 1;
      cdbTag      = 4'($urandom);
      cdbValue    = $urandom;
      readTagA    = 4'($urandom);
      readTagB    = 4'($urandom);
      commitReady = $urandom_range(0, 2) != 0;
      flush       = $urandom_range(0, 63) == 0;
      if (i % 700 == 350) begin
        #2 reset = 1'b1;
        step();
        reset = 1'b0;
      end else begin
        step();
      end
    end
    allocValid = 1'b0; cdbValid = 1'b0; commitReady = 1'b0; flush = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter REORDER_BUFFER_SIZE_LOG, default 4, log2 of entry count (16 entries).
REQ-002 SHALL have parameter REGISTER_NUMBER_LOG, default 5, destination register index width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, result value width.
REQ-004 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have allocValid  input  1  dispatch requests a new entry.
REQ-007 SHALL have allocDest  input  REGISTER_NUMBER_LOG  destination register of the dispatched instruction.
REQ-008 SHALL have allocReady  output  1  buffer not full; alloc accepted this cycle when allocValid && allocReady.
REQ-009 SHALL have allocTag  output  REORDER_BUFFER_SIZE_LOG  tag (tail index) given to the allocating instruction; drives status-table writeValue.
REQ-010 SHALL have cdbValid, cdbTag, cdbValue  inputs  1 / REORDER_BUFFER_SIZE_LOG / DATA_WIDTH  result broadcast.
REQ-011 SHALL have readTagA, readTagB  inputs  REORDER_BUFFER_SIZE_LOG  operand lookup tags from the status table.
REQ-012 SHALL have readReadyA/B  outputs  1, readDataA/B  outputs  DATA_WIDTH  lookup entry has a result / that result.
REQ-013 SHALL have commitValid  output  1, commitDest  output  REGISTER_NUMBER_LOG, commitValue  output  DATA_WIDTH, commitTag  output  REORDER_BUFFER_SIZE_LOG  head retirement.
REQ-014 SHALL have commitReady  input  1  consumer accepts the head entry.
REQ-015 SHALL have flush  input  1  synchronous clear of all entries.
REQ-016 SHALL have count  output  REORDER_BUFFER_SIZE_LOG+1  occupied entries.

Function
REQ-017 SHALL store per entry: busy, done, dest, value; head, tail pointers wrap modulo 2^REORDER_BUFFER_SIZE_LOG.
REQ-018 SHALL drive allocReady = (count != 2^REORDER_BUFFER_SIZE_LOG) from registered count; a same-cycle commit does not free space for a same-cycle alloc.
REQ-019 SHALL drive allocTag = tail combinationally; on accepted alloc, entry[tail] gets busy=1, done=0, dest=allocDest, and tail advances by one.
REQ-020 SHALL, on cdbValid with entry[cdbTag].busy=1, set done=1 and value=cdbValue next edge; cdbValid to a non-busy tag is ignored.
REQ-021 SHALL ignore a CDB write to the tag being allocated in the same cycle (entry not yet busy); alloc initialises done=0.
REQ-022 SHALL drive commitValid = entry[head].busy && entry[head].done; commitDest, commitValue, commitTag = head entry fields, zero-latency.
REQ-023 SHALL, on commitValid && commitReady, clear entry[head].busy and advance head by one; at most one commit per cycle.
REQ-024 SHALL update count by +1 for accepted alloc, -1 for commit, unchanged when both occur.
REQ-025 SHALL drive readReadyX = entry[readTagX].busy && done, readDataX = entry[readTagX].value; readDataX is 0 when readReadyX=0.
REQ-026 SHALL give flush priority over alloc, CDB, and commit: next edge all busy=0, head=tail=0, count=0.
REQ-027 SHALL keep full/empty unambiguous via count, not pointer comparison.

Reset
REQ-028 SHALL, on reset assertion, immediately clear all busy/done bits, head=tail=0, count=0, independent of clk.
REQ-029 SHALL hold reset outputs: allocReady=1, allocTag=0, commitValid=0, commitDest=0, commitValue=0, commitTag=0, readReadyA/B=0, count=0.
REQ-030 SHALL abandon any in-flight alloc, CDB, or commit when reset asserts mid-cycle.

Configuration
REQ-031 SHALL support macro REORDER_BUFFER_BYPASS_EN.
REQ-032 SHALL, with REORDER_BUFFER_BYPASS_EN defined, forward a same-cycle valid CDB write to read ports (readTagX == cdbTag, entry busy) and to commit outputs when cdbTag == head.
REQ-033 SHALL, without REORDER_BUFFER_BYPASS_EN, expose CDB results on read and commit outputs only from the edge after the write.

Verification
REQ-034 Reset, then 16 allocs with allocDest=1..16 (mod 32) -> allocTag 0..15, count=16, allocReady=0; 17th allocValid not accepted, tail stays 0.
REQ-035 Allocs tags 0,1; CDB tag1 value 0xBEEF then tag0 value 0x1234 -> commitValid low until tag0 done; commits tag0 (0x1234) then tag1 (0xBEEF) in order.
REQ-036 Full buffer, head done, allocValid && commitReady same cycle -> commit occurs, alloc rejected, count=15, allocReady=1 next cycle.
REQ-037 Tail wrap: 20 alloc/commit pairs -> allocTag sequence 0..15,0..3; count never exceeds 16.
REQ-038 Bypass: CDB tag3 value 0xA5 with readTagA=3 -> readReadyA=1, readDataA=0xA5 same cycle with REORDER_BUFFER_BYPASS_EN, next cycle without.
REQ-039 Flush with 5 entries and simultaneous alloc/CDB -> next cycle count=0, commitValid=0, allocTag=0; reset mid-stream -> same values asynchronously.
